pkt_word_tracker: RTL and testbench
===================================

Name: pkt_word_tracker

Overview:
Parametrised successor to the per-packet word-position tracker used in the output port lookup pipeline.
- Tracks beat position within AXI-Stream packets over C_HDR_WORDS header words, not a fixed two.
- Advances only on accepted beats (tvalid & tready).
- At end of packet, queues one metadata entry in an internal FIFO of configurable depth: source port, from-CPU flag, short-packet flag, beat count.
- Sits beside the header parsers and feeds the lookup/decision stage, which pops entries.

Parameters:
C_S_AXIS_TUSER_WIDTH, 128, tuser width
C_HDR_WORDS, 2, number of header beats indexed individually (>=1, <=16)
C_SRC_PORT_OFF, 16, bit offset of 8-bit one-hot source-port field in tuser
C_CPU_PORT_MASK, 8'hAA, source-port bits that denote CPU (DMA) ports
C_META_DEPTH_BITS, 2, log2 of metadata FIFO depth (depth = 4 by default)

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
i_tuser  in  C_S_AXIS_TUSER_WIDTH  stream sideband, sampled on first beat
i_tvalid  in  1  stream valid
i_tready  in  1  stream ready (observed, not driven)
i_tlast  in  1  end of packet
i_meta_rd  in  1  pop head metadata entry
o_hdr_word  out  C_HDR_WORDS  one-hot: current accepted beat is header word i
o_payload  out  1  current accepted beat lies beyond header words
o_meta_valid  out  1  FIFO not empty
o_meta_src_port  out  8  head entry source port (one-hot)
o_meta_from_cpu  out  1  head entry: (src_port & C_CPU_PORT_MASK) != 0
o_meta_short  out  1  head entry: packet had fewer than C_HDR_WORDS beats
o_meta_beats  out  16  head entry: beat count, saturating at 16'hFFFF
o_meta_full  out  1  FIFO full, so upstream must hold tready low at EOP
o_overflow  out  1  sticky: an entry was dropped

Behaviour:
- beat = i_tvalid & i_tready. Nothing advances without beat; tvalid without tready is a stall.
- Word counter cnt: width clog2(C_HDR_WORDS+1), reset 0.
  - On beat with tlast: cnt <= 0.
  - On beat without tlast: cnt <= cnt+1, saturating at C_HDR_WORDS (payload state).
- States: HDR(i) for cnt=i < C_HDR_WORDS; PAYLOAD for cnt=C_HDR_WORDS. From any state, beat with tlast returns to HDR(0).
- o_hdr_word[i] = beat & (cnt==i). o_payload = beat & (cnt==C_HDR_WORDS). Both are combinational, zero latency, and 0 in reset.
- Source port:
  - Captured from i_tuser[C_SRC_PORT_OFF +: 8] on the HDR(0) beat.
  - For the entry, the HDR(0) beat uses the live tuser value, so single-beat packets are correct.
- Beat counter: reset 0. Counts beats of the current packet and saturates at 16'hFFFF; the EOP beat is included. Cleared after EOP.
- Entry write: {src_port, from_cpu, short, beats} is written at the clock edge that accepts the tlast beat.
  - o_meta_valid rises on the following cycle (latency 1).
  - short = (beats incl. EOP) < C_HDR_WORDS.
- FIFO is first-word-fallthrough. o_meta_* show the head whenever o_meta_valid=1 and are 0 when empty.
- i_meta_rd when empty is ignored: no underflow, state unchanged.
- Write when full without simultaneous read: entry dropped, o_overflow <= 1 (held until reset), tracking still advances normally.
- Write when full with simultaneous i_meta_rd: both are honoured and occupancy is unchanged.
- Write and read when non-empty and non-full: occupancy unchanged, order preserved.
- Pointers wrap modulo 2^C_META_DEPTH_BITS.
- o_meta_full = occupancy == 2^C_META_DEPTH_BITS.
- Reset (asynchronous assert, synchronous-released deassert by the system) at any time, including mid-packet:
  - Clears cnt, beat counter, FIFO pointers, occupancy and o_overflow. All outputs go to 0.
  - The next accepted beat is treated as HDR(0), even if the stream was mid-packet.

Test Plan:
1. C_HDR_WORDS=3. 5-beat packet, tuser src=8'h01, no stalls -> o_hdr_word = 001,010,100 on beats 1-3; o_payload on beats 4-5. One cycle after EOP: o_meta_valid=1, src=01, from_cpu=0, short=0, beats=5.
2. 1-beat packet, src=8'h02 -> o_hdr_word[0]=1 and tlast on the same beat. Entry: src=02, from_cpu=1, short=1, beats=1. Next packet starts at HDR(0).
3. 4-beat packet with tready low for 3 cycles mid-packet while tvalid=1 -> no word outputs during the stall, cnt held, entry beats=4.
4. Depth 4: five packets with i_meta_rd=0 -> o_meta_full=1 after 4th; 5th dropped, o_overflow=1. Pop 4 -> src order matches packets 1-4, then o_meta_valid=0. An extra pop is ignored.
5. FIFO full, and an EOP beat coincides with i_meta_rd=1 -> no drop, o_overflow stays 0, occupancy stays 4, new entry last.
6. Assert axi_resetn=0 asynchronously mid-packet at beat 2 of 6 -> outputs 0 immediately. After release, the next beat drives o_hdr_word[0]=1 and FIFO is empty.

Source files
------------

// File: rtl/pkt_word_tracker_if.sv
// Purpose : bundles the observed AXI-Stream beat, the metadata pop request and
//           the tracker's word-position / metadata-FIFO outputs.
// Ports   : master = stream/lookup side (drives i_*), slave = tracker (drives o_*).
interface pkt_word_tracker_if #(
  parameter int TUSER_W   = 128,
  parameter int HDR_WORDS = 2
);
  logic [TUSER_W-1:0]   i_tuser;
  logic                 i_tvalid;
  logic                 i_tready;
  logic                 i_tlast;
  logic                 i_meta_rd;
  logic [HDR_WORDS-1:0] o_hdr_word;
  logic                 o_payload;
  logic                 o_meta_valid;
  logic [7:0]           o_meta_src_port;
  logic                 o_meta_from_cpu;
  logic                 o_meta_short;
  logic [15:0]          o_meta_beats;
  logic                 o_meta_full;
  logic                 o_overflow;

  modport master (
    output i_tuser, i_tvalid, i_tready, i_tlast, i_meta_rd,
    input  o_hdr_word, o_payload, o_meta_valid, o_meta_src_port,
           o_meta_from_cpu, o_meta_short, o_meta_beats, o_meta_full, o_overflow
  );

  modport slave (
    input  i_tuser, i_tvalid, i_tready, i_tlast, i_meta_rd,
    output o_hdr_word, o_payload, o_meta_valid, o_meta_src_port,
           o_meta_from_cpu, o_meta_short, o_meta_beats, o_meta_full, o_overflow
  );
endinterface

// File: rtl/pkt_word_tracker.sv
// Purpose : tracks beat position (header word i / payload) inside AXI-Stream packets
//           and queues one metadata entry per packet in a first-word-fallthrough FIFO.
// Latency : o_hdr_word/o_payload combinational (0); entry visible on o_meta_* 1 cycle after EOP.
// Backpr. : observes tvalid&tready only; upstream must hold tready low at EOP while
//           o_meta_full (else entry dropped, o_overflow sticky). i_meta_rd on empty is ignored.
// Ports   : axi_aclk, axi_resetn (async active-low), bus (pkt_word_tracker_if.slave).
module pkt_word_tracker #(
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         C_HDR_WORDS          = 2,
  parameter int         C_SRC_PORT_OFF       = 16,
  parameter logic [7:0] C_CPU_PORT_MASK      = 8'hAA,
  parameter int         C_META_DEPTH_BITS    = 2
) (
  input  logic              axi_aclk,
  input  logic              axi_resetn,
  pkt_word_tracker_if.slave bus
);

  localparam int            CW          = $clog2(C_HDR_WORDS + 1);
  localparam int            DB          = C_META_DEPTH_BITS;
  localparam int            DEPTH       = 1 << DB;
  localparam logic [CW-1:0] CNT_PAYLOAD = CW'(C_HDR_WORDS);

  typedef struct packed {
    logic [7:0]  src_port;
    logic        from_cpu;
    logic        short_pkt;
    logic [15:0] beats;
  } meta_t;

  // Gating with reset keeps the combinational outputs at 0 while reset is held.
  logic beat;
  assign beat = bus.i_tvalid & bus.i_tready & axi_resetn;

  // ---------------- word position counter (state register + next state) -----
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (beat) begin
      if (bus.i_tlast)                cnt_d = '0;
      else if (cnt_q != CNT_PAYLOAD)  cnt_d = cnt_q + CW'(1);
    end
  end

  logic [C_HDR_WORDS-1:0] hdr_word;
  always_comb begin
    hdr_word = '0;
    for (int i = 0; i < C_HDR_WORDS; i++) begin
      hdr_word[i] = beat && (cnt_q == CW'(i));
    end
  end

  assign bus.o_hdr_word = hdr_word;
  assign bus.o_payload  = beat && (cnt_q == CNT_PAYLOAD);

  // ---------------- per-packet fields ---------------------------------------
  logic [7:0]  src_q, src_cur;
  logic [15:0] beats_q, beats_inc;
  logic        first_beat;

  assign first_beat = (cnt_q == '0);
  // On the first beat use the live field so single-beat packets are correct.
  assign src_cur    = first_beat ? bus.i_tuser[C_SRC_PORT_OFF +: 8] : src_q;
  assign beats_inc  = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      src_q   <= '0;
      beats_q <= '0;
    end else if (beat) begin
      if (first_beat) src_q <= bus.i_tuser[C_SRC_PORT_OFF +: 8];
      beats_q <= bus.i_tlast ? 16'd0 : beats_inc;
    end
  end

  meta_t entry;
  always_comb begin
    entry           = '0;
    entry.src_port  = src_cur;
    entry.from_cpu  = |(src_cur & C_CPU_PORT_MASK);
    entry.short_pkt = (beats_inc < 16'(C_HDR_WORDS));
    entry.beats     = beats_inc;
  end

  // ---------------- metadata FIFO (first-word-fallthrough) ------------------
  meta_t         mem [DEPTH];
  logic [DB-1:0] wr_ptr, rd_ptr;
  logic [DB:0]   occ;
  logic          full, empty, wr_req, wr_en, rd_en, overflow_q;

  assign empty  = (occ == '0);
  assign full   = (occ == (DB+1)'(DEPTH));
  assign wr_req = beat & bus.i_tlast;
  assign rd_en  = bus.i_meta_rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en  = wr_req & (~full | rd_en);

  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DB'(1);
      if (rd_en) rd_ptr <= rd_ptr + DB'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + (DB+1)'(1);
        2'b01:   occ <= occ - (DB+1)'(1);
        default: occ <= occ;
      endcase
      if (wr_req && !wr_en) overflow_q <= 1'b1;
    end
  end

  meta_t head;
  assign head = empty ? '0 : mem[rd_ptr];

  assign bus.o_meta_valid    = ~empty;
  assign bus.o_meta_src_port = head.src_port;
  assign bus.o_meta_from_cpu = head.from_cpu;
  assign bus.o_meta_short    = head.short_pkt;
  assign bus.o_meta_beats    = head.beats;
  assign bus.o_meta_full     = full;
  assign bus.o_overflow      = overflow_q;

  // Only the source-port field of tuser is consumed.
  logic unused_tuser;
  assign unused_tuser = &{1'b0, bus.i_tuser};

endmodule

// File: tb/tb_pkt_word_tracker.sv
// Directed bench for pkt_word_tracker with 3 header words and a 4-deep metadata FIFO.
module tb_pkt_word_tracker;
  localparam int TW = 128;
  localparam int HW = 3;

  logic axi_aclk   = 1'b0;
  logic axi_resetn = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  pkt_word_tracker_if #(.TUSER_W(TW), .HDR_WORDS(HW)) bus ();

  pkt_word_tracker #(
    .C_S_AXIS_TUSER_WIDTH(TW),
    .C_HDR_WORDS(HW),
    .C_SRC_PORT_OFF(16),
    .C_CPU_PORT_MASK(8'hAA),
    .C_META_DEPTH_BITS(2)
  ) dut (
    .axi_aclk(axi_aclk),
    .axi_resetn(axi_resetn),
    .bus(bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Drive one cycle of inputs after the falling edge; outputs are settled #1 later.
  task automatic set_in(input logic v, input logic r, input logic l,
                        input logic [7:0] src, input logic rd);
    logic [TW-1:0] tu;
    @(negedge axi_aclk);
    tu            = {4{32'hC35A_A53C}};
    tu[23:16]     = src;
    bus.i_tuser   = tu;
    bus.i_tvalid  = v;
    bus.i_tready  = r;
    bus.i_tlast   = l;
    bus.i_meta_rd = rd;
    #1;
  endtask

  task automatic test_reset();
    bus.i_tuser = '0; bus.i_tvalid = 1'b1; bus.i_tready = 1'b1;
    bus.i_tlast = 1'b0; bus.i_meta_rd = 1'b1;
    #2;
    cmp_cnt++; if (bus.o_hdr_word !== 3'b000) begin err_cnt++; $display("FAIL rst_hdr_word: got %b want 000", bus.o_hdr_word); end
    cmp_cnt++; if (bus.o_payload !== 1'b0) begin err_cnt++; $display("FAIL rst_payload: got %b want 0", bus.o_payload); end
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_meta_valid: got %b want 0", bus.o_meta_valid); end
    cmp_cnt++; if (bus.o_meta_full !== 1'b0) begin err_cnt++; $display("FAIL rst_meta_full: got %b want 0", bus.o_meta_full); end
    cmp_cnt++; if (bus.o_overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_overflow: got %b want 0", bus.o_overflow); end
    cmp_cnt++; if (bus.o_meta_beats !== 16'd0) begin err_cnt++; $display("FAIL rst_meta_beats: got %0d want 0", bus.o_meta_beats); end
    bus.i_tvalid = 1'b0; bus.i_tready = 1'b0; bus.i_meta_rd = 1'b0;
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
  endtask

  task automatic test_long_packet();
    logic [2:0] exp_hw [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    logic       exp_pl [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b1, (i == 4), (i == 0) ? 8'h01 : 8'hF0, 1'b0);
      cmp_cnt++; if (bus.o_hdr_word !== exp_hw[i]) begin err_cnt++; $display("FAIL long_hdr_word beat %0d: got %b want %b", i+1, bus.o_hdr_word, exp_hw[i]); end
      cmp_cnt++; if (bus.o_payload !== exp_pl[i]) begin err_cnt++; $display("FAIL long_payload beat %0d: got %b want %b", i+1, bus.o_payload, exp_pl[i]); end
    end
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL long_valid_before_eop_edge: got %b want 0", bus.o_meta_valid); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_valid !== 1'b1) begin err_cnt++; $display("FAIL long_meta_valid: got %b want 1", bus.o_meta_valid); end
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h01) begin err_cnt++; $display("FAIL long_src: got %h want 01", bus.o_meta_src_port); end
    cmp_cnt++; if (bus.o_meta_from_cpu !== 1'b0) begin err_cnt++; $display("FAIL long_from_cpu: got %b want 0", bus.o_meta_from_cpu); end
    cmp_cnt++; if (bus.o_meta_short !== 1'b0) begin err_cnt++; $display("FAIL long_short: got %b want 0", bus.o_meta_short); end
    cmp_cnt++; if (bus.o_meta_beats !== 16'd5) begin err_cnt++; $display("FAIL long_beats: got %0d want 5", bus.o_meta_beats); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL long_after_pop_valid: got %b want 0", bus.o_meta_valid); end
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h00) begin err_cnt++; $display("FAIL long_empty_src: got %h want 00", bus.o_meta_src_port); end
  endtask

  task automatic test_single_beat();
    set_in(1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b001) begin err_cnt++; $display("FAIL single_hdr_word: got %b want 001", bus.o_hdr_word); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h02) begin err_cnt++; $display("FAIL single_src: got %h want 02", bus.o_meta_src_port); end
    cmp_cnt++; if (bus.o_meta_from_cpu !== 1'b1) begin err_cnt++; $display("FAIL single_from_cpu: got %b want 1", bus.o_meta_from_cpu); end
    cmp_cnt++; if (bus.o_meta_short !== 1'b1) begin err_cnt++; $display("FAIL single_short: got %b want 1", bus.o_meta_short); end
    cmp_cnt++; if (bus.o_meta_beats !== 16'd1) begin err_cnt++; $display("FAIL single_beats: got %0d want 1", bus.o_meta_beats); end
    set_in(1'b1, 1'b1, 1'b0, 8'h04, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b001) begin err_cnt++; $display("FAIL next_pkt_hdr0: got %b want 001", bus.o_hdr_word); end
    set_in(1'b1, 1'b1, 1'b1, 8'hF0, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b010) begin err_cnt++; $display("FAIL next_pkt_hdr1: got %b want 010", bus.o_hdr_word); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h02) begin err_cnt++; $display("FAIL two_entry_head: got %h want 02", bus.o_meta_src_port); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h04) begin err_cnt++; $display("FAIL two_beat_src: got %h want 04", bus.o_meta_src_port); end
    cmp_cnt++; if (bus.o_meta_short !== 1'b1) begin err_cnt++; $display("FAIL two_beat_short: got %b want 1", bus.o_meta_short); end
    cmp_cnt++; if (bus.o_meta_beats !== 16'd2) begin err_cnt++; $display("FAIL two_beat_beats: got %0d want 2", bus.o_meta_beats); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL single_drain_valid: got %b want 0", bus.o_meta_valid); end
  endtask

  task automatic test_stall();
    set_in(1'b1, 1'b1, 1'b0, 8'h10, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b001) begin err_cnt++; $display("FAIL stall_beat1: got %b want 001", bus.o_hdr_word); end
    set_in(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b010) begin err_cnt++; $display("FAIL stall_beat2: got %b want 010", bus.o_hdr_word); end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 8'hF0, 1'b0);
      cmp_cnt++; if ({bus.o_hdr_word, bus.o_payload} !== 4'b0000) begin err_cnt++; $display("FAIL stall_cycle %0d: got %b want 0000", i, {bus.o_hdr_word, bus.o_payload}); end
    end
    set_in(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b100) begin err_cnt++; $display("FAIL stall_beat3: got %b want 100", bus.o_hdr_word); end
    set_in(1'b1, 1'b1, 1'b1, 8'hF0, 1'b0);
    cmp_cnt++; if (bus.o_payload !== 1'b1) begin err_cnt++; $display("FAIL stall_beat4_payload: got %b want 1", bus.o_payload); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cmp_cnt++; if (bus.o_meta_beats !== 16'd4) begin err_cnt++; $display("FAIL stall_beats: got %0d want 4", bus.o_meta_beats); end
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h10) begin err_cnt++; $display("FAIL stall_src: got %h want 10", bus.o_meta_src_port); end
    cmp_cnt++; if (bus.o_meta_short !== 1'b0) begin err_cnt++; $display("FAIL stall_short: got %b want 0", bus.o_meta_short); end
  endtask

  task automatic test_overflow();
    logic [7:0] srcs [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 0; i < 4; i++) set_in(1'b1, 1'b1, 1'b1, srcs[i], 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_full !== 1'b1) begin err_cnt++; $display("FAIL ovf_full_after4: got %b want 1", bus.o_meta_full); end
    cmp_cnt++; if (bus.o_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_flag_after4: got %b want 0", bus.o_overflow); end
    set_in(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b001) begin err_cnt++; $display("FAIL ovf_tracking: got %b want 001", bus.o_hdr_word); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag_set: got %b want 1", bus.o_overflow); end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cmp_cnt++; if (bus.o_meta_src_port !== srcs[i]) begin err_cnt++; $display("FAIL ovf_pop %0d: got %h want %h", i, bus.o_meta_src_port, srcs[i]); end
    end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drained_valid: got %b want 0", bus.o_meta_valid); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if ({bus.o_meta_valid, bus.o_meta_full} !== 2'b00) begin err_cnt++; $display("FAIL ovf_extra_pop: got %b want 00", {bus.o_meta_valid, bus.o_meta_full}); end
    cmp_cnt++; if (bus.o_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow); end
    // A stray pop must not have moved the pointers: one new entry comes out intact.
    set_in(1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h20) begin err_cnt++; $display("FAIL ovf_after_underflow: got %h want 20", bus.o_meta_src_port); end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] exp [4] = '{8'h02, 8'h04, 8'h08, 8'h80};
    @(negedge axi_aclk);
    axi_resetn = 1'b0;
    #1;
    cmp_cnt++; if (bus.o_overflow !== 1'b0) begin err_cnt++; $display("FAIL fwp_reset_overflow: got %b want 0", bus.o_overflow); end
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 8'h04, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 8'h08, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 8'h80, 1'b1);
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h01) begin err_cnt++; $display("FAIL fwp_head_before: got %h want 01", bus.o_meta_src_port); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_full !== 1'b1) begin err_cnt++; $display("FAIL fwp_still_full: got %b want 1", bus.o_meta_full); end
    cmp_cnt++; if (bus.o_overflow !== 1'b0) begin err_cnt++; $display("FAIL fwp_no_overflow: got %b want 0", bus.o_overflow); end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cmp_cnt++; if (bus.o_meta_src_port !== exp[i]) begin err_cnt++; $display("FAIL fwp_order %0d: got %h want %h", i, bus.o_meta_src_port, exp[i]); end
    end
    cmp_cnt++; if (bus.o_meta_from_cpu !== 1'b1) begin err_cnt++; $display("FAIL fwp_last_from_cpu: got %b want 1", bus.o_meta_from_cpu); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL fwp_drained: got %b want 0", bus.o_meta_valid); end
  endtask

  task automatic test_reset_mid_packet();
    set_in(1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b010) begin err_cnt++; $display("FAIL mid_beat2: got %b want 010", bus.o_hdr_word); end
    axi_resetn = 1'b0;
    #1;
    cmp_cnt++; if (bus.o_hdr_word !== 3'b000) begin err_cnt++; $display("FAIL mid_rst_hdr: got %b want 000", bus.o_hdr_word); end
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid: got %b want 0", bus.o_meta_valid); end
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h00) begin err_cnt++; $display("FAIL mid_rst_src: got %h want 00", bus.o_meta_src_port); end
    bus.i_tvalid = 1'b0;
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 8'h08, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b001) begin err_cnt++; $display("FAIL mid_after_hdr0: got %b want 001", bus.o_hdr_word); end
    cmp_cnt++; if (bus.o_meta_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_after_empty: got %b want 0", bus.o_meta_valid); end
    set_in(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 8'hF0, 1'b0);
    cmp_cnt++; if (bus.o_hdr_word !== 3'b100) begin err_cnt++; $display("FAIL mid_after_hdr2: got %b want 100", bus.o_hdr_word); end
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cmp_cnt++; if (bus.o_meta_src_port !== 8'h08) begin err_cnt++; $display("FAIL mid_after_src: got %h want 08", bus.o_meta_src_port); end
    cmp_cnt++; if (bus.o_meta_beats !== 16'd3) begin err_cnt++; $display("FAIL mid_after_beats: got %0d want 3", bus.o_meta_beats); end
    cmp_cnt++; if (bus.o_meta_from_cpu !== 1'b1) begin err_cnt++; $display("FAIL mid_after_from_cpu: got %b want 1", bus.o_meta_from_cpu); end
  endtask

  initial begin
    test_reset();
    test_long_packet();
    test_single_beat();
    test_stall();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
